// File: rtl/tt_vector_checker.sv
// Truth-table checker for 3-input combinational blocks: sweeps {A,B,C} through 000..111,
// samples four candidate outputs at the end of each hold and records mismatches.
module tt_vector_checker #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [7:0]  EXP_TT      = 8'hE8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] f_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [3:0] err_mask,
    output logic [2:0] first_err_idx
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrive = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [7:0] LastHold = 8'(HOLD_CYCLES - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [7:0] holdCnt;
    logic [2:0] vec;
    logic [3:0] fail;
    logic [3:0] errCountNext;

    // vec is a separate register so A/B/C return to 000 in DONE while idx stays at 7.
    assign {A, B, C} = vec;

    always_comb begin
        fail         = f_in ^ {4{EXP_TT[idx]}};
        errCountNext = err_count + {3'b000, (fail != 4'b0000)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            idx           <= 3'd0;
            holdCnt       <= 8'd0;
            vec           <= 3'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 4'd0;
            err_mask      <= 4'd0;
            first_err_idx <= 3'd0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state         <= StDrive;
                        idx           <= 3'd0;
                        holdCnt       <= 8'd0;
                        vec           <= 3'd0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= 4'd0;
                        err_mask      <= 4'd0;
                        first_err_idx <= 3'd0;
                    end
                end
                StDrive: begin
                    if (holdCnt == LastHold) begin
                        if (fail != 4'b0000) begin
                            err_count <= errCountNext;
                            err_mask  <= err_mask | fail;
                            if (err_count == 4'd0) begin
                                first_err_idx <= idx;
                            end
                        end
                        if (idx == 3'd7) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (errCountNext == 4'd0);
                            vec   <= 3'd0;
                        end else begin
                            idx     <= idx + 3'd1;
                            holdCnt <= 8'd0;
                            vec     <= idx + 3'd1;
                        end
                    end else begin
                        holdCnt <= holdCnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/tt_vector_checker.md
Name: tt_vector_checker

Overview:
Hardware counterpart of a truth-table bench for 3-input combinational blocks. It drives A/B/C through all 8 combinations in ascending order and holds each vector for HOLD_CYCLES clocks. At the end of each hold it samples up to four candidate implementations (simp/pos/sop/case) and checks each against an expected truth table. Mismatches are counted and located so a board-level lab can self-check without a simulator.

Parameters:
HOLD_CYCLES, 20, clocks each vector is held (legal range 2..255)
EXP_TT, 8'hE8, expected output per vector; bit i = expected F for {A,B,C}=i (default = 3-input majority)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle run request; honoured only in IDLE or DONE
f_in  input  4  DUT outputs: bit0 Fsimp, bit1 Fpos, bit2 Fsop, bit3 Fcase
A  output  1  stimulus MSB (vector bit 2), registered
B  output  1  stimulus bit 1, registered
C  output  1  stimulus LSB (vector bit 0), registered
busy  output  1  high while vectors are being driven
done  output  1  high in DONE until next start or rst
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  4  number of vectors with at least one failing f_in bit (0..8)
err_mask  output  4  sticky per-output fail flags, bit mapping as f_in
first_err_idx  output  3  index of first failing vector; valid when err_count!=0

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. A/B/C=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, first_err_idx=0, internal idx=0, hold_cnt=0. Takes priority over everything, including mid-run; no partial results are retained.
- FSM states: IDLE, DRIVE, DONE.
- IDLE, start=1: next cycle state=DRIVE, busy=1, idx=0, hold_cnt=0, {A,B,C}=000. err_count, err_mask, first_err_idx and done are cleared.
- DRIVE:
  - {A,B,C}=idx throughout.
  - hold_cnt increments each clock.
  - On the cycle where hold_cnt==HOLD_CYCLES-1 (sample cycle), compute fail = f_in XOR {4{EXP_TT[idx]}}.
  - If fail!=0: err_count += 1; err_mask |= fail; if err_count was 0, first_err_idx=idx.
- Transition out of a sample cycle:
  - idx<7: idx+1, hold_cnt=0.
  - idx==7: state=DONE, busy=0, done=1, pass=(final err_count==0), A/B/C return to 000.
- Timing: each vector is present on A/B/C for exactly HOLD_CYCLES cycles. busy is high for exactly 8*HOLD_CYCLES cycles. done rises the cycle after the 8th sample.
- f_in is sampled only at the sample cycle; changes at any other time are ignored. The DUT must settle within HOLD_CYCLES-1 clocks.
- start while in DRIVE is ignored; the sequence is unaffected.
- DONE, start=1: behaves as start from IDLE (restart, results cleared).
- DONE without start: results hold indefinitely.
- err_count cannot overflow (max 8, 4-bit).
- idx is 3 bits and does not wrap; termination is at idx==7.
- Results are updated on the sample cycle's edge, so err_count is stable one cycle after each sample.

Test Plan:
- Golden DUT (all four f_in = majority(A,B,C)), HOLD_CYCLES=4, start pulse -> busy high 32 cycles; A/B/C step 000..111 every 4 cycles; then done=1, pass=1, err_count=0, err_mask=0000.
- Fsop stuck at 0, others majority -> fails at idx 3,5,6,7: err_count=4, err_mask=0100, first_err_idx=3, pass=0.
- Fcase inverted and Fpos stuck at 1 -> every vector fails: err_count=8, err_mask=1010, first_err_idx=0, pass=0.
- start re-pulsed at cycle 10 of a golden run -> vector sequence and 32-cycle busy window unchanged; result pass=1.
- rst asserted while idx=4 -> next cycle A/B/C=000, busy=0, done=0, err_count=0. A subsequent start runs the full 8 vectors from 000.
- After a failing run (err_count=4), start again with a golden DUT -> counters cleared at start; final err_count=0, pass=1.
